alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter DEBUG_DEFAULT, default 0, initial value of the per-operation trace display enable.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the operation request handshake.
REQ-006 SHALL have port opcode  input  4  ARM data-processing opcode: AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
REQ-007 SHALL have ports mul input 1 (multiply request, overrides opcode) and s input 1 (update flags).
REQ-008 SHALL have ports op_a, op_b and op_c, input, WIDTH each: first operand, second operand and accumulate operand.
REQ-009 SHALL have port shift_c  input  1  shifter carry-out, used as C for logical ops.
REQ-010 SHALL have ports flags_wr input 1 and flags_in input 4, external NZCV load (MSR).
REQ-011 SHALL have ports out_valid output 1, result output WIDTH, res_we output 1 and flags output 4 (NZCV, registered).

Function
REQ-012 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1.
REQ-013 SHALL complete a non-multiply operation in 1 cycle: result, res_we and out_valid are registered at the accepting edge.
- out_valid is a one-cycle pulse; there is no output backpressure.
- in_ready stays 1, giving throughput of 1 operation per cycle.
REQ-014 SHALL compute arithmetic at WIDTH+1 bits.
- ADD/ADC/CMN: C = carry-out.
- SUB/SBC/RSB/RSC/CMP: C = NOT borrow.
- ADC uses the registered C flag; SBC/RSC subtract NOT C.
- V = signed overflow of the actual operation, with the operand order swapped for reverse subtracts.
REQ-015 SHALL set N = result[WIDTH-1] and Z = (result == 0) for all ops; logical ops set C = shift_c and leave V unchanged.
REQ-016 SHALL drive res_we = 0 for TST/TEQ/CMP/CMN and always update flags for them, regardless of s.
REQ-017 SHALL leave the flags unchanged when s = 0, except for the compare ops in REQ-016.
REQ-018 SHALL use FSM states IDLE and MUL: IDLE->MUL when a mul op is accepted; MUL->IDLE after WIDTH iterations.
REQ-019 SHALL perform MUL as one shift-add iteration per cycle, keeping the low WIDTH bits of the product.
- in_ready = 0 while in MUL.
- out_valid pulses WIDTH cycles after the accepting edge, and in_ready returns to 1 in that same cycle.
REQ-020 SHALL, for multiply with s = 1, update N and Z only; C and V are unchanged.
REQ-021 SHALL give ALU flag writeback priority over flags_wr when both occur on the same edge.
REQ-022 SHALL, when DEBUG_DEFAULT is 1, print opcode, operands, result and NZCV at every out_valid (simulation only).

Reset
REQ-023 SHALL, on reset, force state to IDLE, flags to 0000, result to 0, out_valid to 0 and res_we to 0; in_ready is 1 from the first cycle after reset.
REQ-024 SHALL, on reset asserted mid-multiply, abort the operation with no out_valid and no flag update.

Configuration
REQ-025 SHALL, with ALU_MC_MLA_EN defined, add op_c to the final product (MLA) at no extra latency.
REQ-026 SHALL, without ALU_MC_MLA_EN defined, ignore op_c and perform MUL only.

Structure
REQ-027 SHALL take the opcode enum, NZCV bit-index constants and FSM state enum from shared package alu_mc_pkg.
REQ-028 SHALL implement the iterative multiplier as sub-module alu_mc_mul (start/done handshake, WIDTH parameter); alu_mc owns the flags and the handshake.

Verification
REQ-029 SHALL cover: ADD, s=1, 0x7FFFFFFF + 0x00000001 -> result 0x80000000, NZCV = 1001, out_valid one cycle later.
REQ-030 SHALL cover: SUB, s=1, 5 - 5 -> result 0, NZCV = 0110; then ADC 1 + 1 -> result 3.
REQ-031 SHALL cover: CMP 3, 7 -> res_we = 0, NZCV = 1000; the preceding result is not overwritten.
REQ-032 SHALL cover: MUL 7 x 6, s=1 -> result 42 exactly 32 cycles after accept, in_ready = 0 throughout, NZ = 00, CV unchanged.
REQ-033 SHALL cover: reset at cycle 10 of a MUL -> no out_valid, flags = 0000, in_ready = 1 on the next cycle.
REQ-034 SHALL cover: flags_wr = 1 with flags_in = 1111 on the same edge as ADD 0 + 0, s=1 -> NZCV = 0100.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode enum, NZCV bit positions, FSM state enum and small
// opcode classification helpers shared by the alu_mc block.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    // Bit positions inside the 4-bit NZCV vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    // Compare/test ops: flags always written, result register untouched
    function automatic logic is_compare(input alu_op_e op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    // Ops that go through the WIDTH+1 bit adder (C/V from the adder)
    function automatic logic is_arith(input alu_op_e op);
        return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC,
                          OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    endfunction

endpackage

// File: rtl/alu_mc_mul.sv
// alu_mc_mul: iterative shift-add multiplier, one partial product per cycle.
// i_start loads the operands; o_done is high in the cycle whose rising edge
// performs the last (WIDTH-th) iteration, with o_product holding that final
// low-WIDTH-bit sum. i_c seeds the accumulator (zero for plain MUL).
module alu_mc_mul
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done     = r_busy && (r_cnt == LAST);
    assign o_product  = w_acc_next;

    // Load on start, then one shift-add step per cycle until the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= i_c;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: single-cycle ARM data-processing ALU with an iterative multiplier.
// Owns the NZCV flags, the request handshake and the IDLE/MUL sequencing.
// Optional feature macro: ALU_MC_MLA_EN adds op_c to the product (MLA).
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEBUG_DEFAULT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             mul,
    input  logic             s,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    input  logic             shift_c,
    input  logic             flags_wr,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             res_we,
    output logic [3:0]       flags
);

    alu_state_e       r_state, w_state_next;
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid, r_res_we, r_mul_s;

    logic             w_in_ready, w_accept, w_alu_go, w_mul_go, w_cmp;
    alu_op_e          w_op;
    logic [WIDTH-1:0] w_x, w_y, w_res;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [3:0]       w_nzcv;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod, w_mul_c;

    assign w_op     = alu_op_e'(opcode);
    assign w_cmp    = is_compare(w_op);
    assign w_accept = in_valid && w_in_ready;
    assign w_alu_go = w_accept && !mul;
    assign w_mul_go = w_accept && mul;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign res_we    = r_res_we;
    assign flags     = r_flags;

`ifdef ALU_MC_MLA_EN
    assign w_mul_c = op_c;
`else
    logic w_unused_opc;
    assign w_mul_c      = '0;
    assign w_unused_opc = ^op_c;
`endif

    alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_mul_go),
        .i_a       (op_a),
        .i_b       (op_b),
        .i_c       (w_mul_c),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // Adder operand select: reverse subtracts swap operands, subtracts invert
    always_comb begin
        w_x   = op_a;
        w_y   = op_b;
        w_cin = 1'b0;
        case (w_op)
            OP_ADC:         w_cin = r_flags[FLAG_C];
            OP_SUB, OP_CMP: begin w_y = ~op_b; w_cin = 1'b1; end
            OP_SBC:         begin w_y = ~op_b; w_cin = r_flags[FLAG_C]; end
            OP_RSB:         begin w_x = op_b; w_y = ~op_a; w_cin = 1'b1; end
            OP_RSC:         begin w_x = op_b; w_y = ~op_a; w_cin = r_flags[FLAG_C]; end
            default:        ;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

    // Result mux and flag generation for single-cycle ops
    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        case (w_op)
            OP_AND, OP_TST: w_res = op_a & op_b;
            OP_EOR, OP_TEQ: w_res = op_a ^ op_b;
            OP_ORR:         w_res = op_a | op_b;
            OP_MOV:         w_res = op_b;
            OP_BIC:         w_res = op_a & ~op_b;
            OP_MVN:         w_res = ~op_b;
            default:        ;
        endcase
        w_nzcv         = r_flags;
        w_nzcv[FLAG_N] = w_res[WIDTH-1];
        w_nzcv[FLAG_Z] = (w_res == '0);
        if (is_arith(w_op)) begin
            w_nzcv[FLAG_C] = w_sum[WIDTH];
            w_nzcv[FLAG_V] = (w_x[WIDTH-1] == w_y[WIDTH-1]) &&
                             (w_res[WIDTH-1] != w_x[WIDTH-1]);
        end else begin
            w_nzcv[FLAG_C] = shift_c;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // FSM next state; requests are only accepted while IDLE
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid && mul) w_state_next = MUL;
            end
            MUL:  if (w_mul_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Flags: ALU/multiply writeback beats an external MSR load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
            r_mul_s <= 1'b0;
        end else begin
            if (w_mul_go) r_mul_s <= s;
            if (w_alu_go && (s || w_cmp)) begin
                r_flags <= w_nzcv;
            end else if (w_mul_done && r_mul_s) begin
                r_flags[FLAG_N] <= w_mul_prod[WIDTH-1];
                r_flags[FLAG_Z] <= (w_mul_prod == '0);
            end else if (flags_wr) begin
                r_flags <= flags_in;
            end
        end
    end

    // Result register and one-cycle completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_res_we    <= 1'b0;
        end else begin
            r_out_valid <= w_alu_go || w_mul_done;
            r_res_we    <= (w_alu_go && !w_cmp) || w_mul_done;
            if (w_alu_go && !w_cmp) r_result <= w_res;
            else if (w_mul_done)    r_result <= w_mul_prod;
        end
    end

`ifndef SYNTHESIS
    logic [3:0]       r_trc_op;
    logic             r_trc_mul;
    logic [WIDTH-1:0] r_trc_a, r_trc_b;

    // Simulation trace: capture operands at accept, print at each completion
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_trc_op  <= opcode;
            r_trc_mul <= mul;
            r_trc_a   <= op_a;
            r_trc_b   <= op_b;
        end
        if ((DEBUG_DEFAULT != 0) && r_out_valid && !reset)
            $display("alu_mc: op=%0h mul=%0b a=%h b=%h res=%h nzcv=%b",
                     r_trc_op, r_trc_mul, r_trc_a, r_trc_b, r_result, r_flags);
    end
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH = 32).
module tb_alu_mc;

    logic        clk, reset, in_valid, in_ready, mul, s, shift_c, flags_wr;
    logic [3:0]  opcode, flags_in, flags;
    logic [31:0] op_a, op_b, op_c, result;
    logic        out_valid, res_we;

    int n_cmp = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(32), .DEBUG_DEFAULT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .mul(mul), .s(s), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .shift_c(shift_c), .flags_wr(flags_wr), .flags_in(flags_in),
        .out_valid(out_valid), .result(result), .res_we(res_we), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request at the negedge; returns 1 time unit after the edge
    task automatic issue(input logic [3:0] op, input logic m, input logic sf,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic shc, input logic fwr, input logic [3:0] fin);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; mul = m; s = sf; op_a = a; op_b = b;
        shift_c = shc; flags_wr = fwr; flags_in = fin;
        @(posedge clk); #1;
        in_valid = 1'b0; mul = 1'b0; flags_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; mul = 1'b0; s = 1'b0; opcode = 4'h0;
        op_a = '0; op_b = '0; op_c = '0; shift_c = 1'b0; flags_wr = 1'b0; flags_in = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", flags); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (res_we !== 1'b0) begin n_err++; $display("FAIL reset_res_we got %b want 0", res_we); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_overflow();
        issue(4'h4, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_out_valid got %b want 1", out_valid); end
        n_cmp++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h want 80000000", result); end
        n_cmp++; if (flags !== 4'b1001) begin n_err++; $display("FAIL add_flags got %b want 1001", flags); end
        n_cmp++; if (res_we !== 1'b1) begin n_err++; $display("FAIL add_res_we got %b want 1", res_we); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse got %b want 0", out_valid); end
    endtask

    // SUB then ADC on consecutive edges: ADC must see the C just written
    task automatic test_back_to_back();
        issue(4'h2, 1'b0, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0, 4'h0);
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL sub_result got %h want 0", result); end
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL sub_flags got %b want 0110", flags); end
        issue(4'h5, 1'b0, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0, 4'h0);
        n_cmp++; if (result !== 32'd3) begin n_err++; $display("FAIL adc_result got %h want 3", result); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL adc_flags got %b want 0000", flags); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL adc_out_valid got %b want 1", out_valid); end
    endtask

    task automatic test_compare();
        issue(4'hA, 1'b0, 1'b0, 32'd3, 32'd7, 1'b0, 1'b0, 4'h0);
        n_cmp++; if (res_we !== 1'b0) begin n_err++; $display("FAIL cmp_res_we got %b want 0", res_we); end
        n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL cmp_flags got %b want 1000", flags); end
        n_cmp++; if (result !== 32'd3) begin n_err++; $display("FAIL cmp_keep_result got %h want 3", result); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL cmp_out_valid got %b want 1", out_valid); end
    endtask

    task automatic test_logic_and_s();
        // s=0: flags stay at 1000 from the compare
        issue(4'h4, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, 1'b0, 4'h0);
        n_cmp++; if (result !== 32'd3) begin n_err++; $display("FAIL adds0_result got %h want 3", result); end
        n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL adds0_flags got %b want 1000", flags); end
        // MOV 0 with shift carry 1: Z=1, C=shift_c, V kept (0)
        issue(4'hD, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 4'h0);
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL mov_result got %h want 0", result); end
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL mov_flags got %b want 0110", flags); end
        // BIC keeps V: preload V=1 then BIC with shift_c=0
        issue(4'hE, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 4'b0001);
        issue(4'hE, 1'b0, 1'b1, 32'hF0F0_00FF, 32'h0000_000F, 1'b0, 1'b0, 4'h0);
        n_cmp++; if (result !== 32'hF0F0_00F0) begin n_err++; $display("FAIL bic_result got %h want f0f000f0", result); end
        n_cmp++; if (flags !== 4'b1001) begin n_err++; $display("FAIL bic_flags got %b want 1001", flags); end
        // RSB 10 - 3 = 7, no borrow
        issue(4'h3, 1'b0, 1'b1, 32'd3, 32'd10, 1'b0, 1'b0, 4'h0);
        n_cmp++; if (result !== 32'd7) begin n_err++; $display("FAIL rsb_result got %h want 7", result); end
        n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL rsb_flags got %b want 0010", flags); end
    endtask

    task automatic test_mul();
        int bad_busy = 0;
        // Preload C=1 V=1 through the MSR path alone
        @(negedge clk); flags_wr = 1'b1; flags_in = 4'b0011;
        @(posedge clk); #1; flags_wr = 1'b0;
        n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL msr_flags got %b want 0011", flags); end
        issue(4'h0, 1'b1, 1'b1, 32'd7, 32'd6, 1'b0, 1'b0, 4'h0);
        if (in_ready !== 1'b0 || out_valid !== 1'b0) bad_busy++;
        for (int k = 1; k < 32; k++) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad_busy++;
        end
        n_cmp++; if (bad_busy != 0) begin n_err++; $display("FAIL mul_busy cycles_wrong %0d want 0", bad_busy); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_out_valid got %b want 1", out_valid); end
        n_cmp++; if (result !== 32'd42) begin n_err++; $display("FAIL mul_result got %h want 2a", result); end
        n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL mul_flags got %b want 0011", flags); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_in_ready got %b want 1", in_ready); end
        n_cmp++; if (res_we !== 1'b1) begin n_err++; $display("FAIL mul_res_we got %b want 1", res_we); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_pulse got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        issue(4'h0, 1'b1, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0, 4'h0);
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmul_out_valid got %b want 0", out_valid); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rstmul_flags got %b want 0000", flags); end
        @(negedge clk); reset = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmul_in_ready got %b want 1", in_ready); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmul_stray_valid count %0d want 0", seen); end
    endtask

    task automatic test_flag_priority();
        issue(4'h4, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 4'b1111);
        n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL prio_flags got %b want 0100", flags); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL prio_result got %h want 0", result); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_compare();
        test_logic_and_s();
        test_mul();
        test_reset_mid_mul();
        test_flag_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
